atari_6116_axil_port: RTL
=========================

// Module: atari_6116_axil_port
// PURPOSE
//  AXI4-Lite slave front end for the emulated 6116 2Kx8 static RAM; downstream of the S00_AXI BFM master.
//  Serialises each 32-bit AXI word access into four byte cycles on one single-port 8-bit array.
//  Shares that array with the emulated CPU's native 6116 pin port. CPU has absolute priority.
// PARAMETERS
//  C_S00_AXI_DATA_WIDTH  32  AXI data width; only 32 is supported.
//  C_S00_AXI_ADDR_WIDTH  32  AXI address width; bits [10:2] select the word, [1:0] are ignored.
//  RAM_DEPTH             2048 bytes in the array; must be a power of 2.
// PORTS
//  s00_axi_aclk     in   1   single clock; all logic is on its rising edge
//  s00_axi_areset   in   1   asynchronous, active-high reset
//  s00_axi_awaddr   in   32  write address;  s00_axi_awvalid in 1, s00_axi_awready out 1
//  s00_axi_wdata    in   32  write data; s00_axi_wstrb in 4; s00_axi_wvalid in 1; s00_axi_wready out 1
//  s00_axi_bresp    out  2   write response; s00_axi_bvalid out 1; s00_axi_bready in 1
//  s00_axi_araddr   in   32  read address;   s00_axi_arvalid in 1, s00_axi_arready out 1
//  s00_axi_rdata    out  32  read data; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1
//  cpu_ce_n         in   1   CPU chip enable, active low
//  cpu_we_n         in   1   CPU write enable, active low (write when cpu_ce_n=0 and cpu_we_n=0)
//  cpu_addr         in   11  CPU byte address
//  cpu_din          in   8   CPU write data
//  cpu_dout         out  8   CPU read data, valid 1 cycle after the read cycle; otherwise holds
// BEHAVIOUR
//  - Reset: every ready/valid output is 0; bresp=rresp=2'b00; rdata=0; cpu_dout=0; FSM=IDLE; byte counter=0.
//    Array contents are not reset.
//  - FSM states: IDLE, WR_BYTE, WR_RESP, RD_BYTE, RD_WAIT, RD_RESP.
//  - IDLE, write: when awvalid && wvalid, pulse awready and wready together for 1 cycle, latch addr/data/strb,
//    then go to WR_BYTE. AW-only or W-only is never accepted.
//  - IDLE, read: when arvalid and no write is pending, pulse arready for 1 cycle, latch addr, then go to RD_BYTE.
//    A write wins over a read that arrives in the same cycle.
//  - WR_BYTE: counter k runs 0..3. Lane k writes byte (word_idx<<2)+k = wdata[8k+7:8k] only if wstrb[k]=1.
//    Lanes with strb=0 still use a cycle. After k=3, go to WR_RESP.
//  - RD_BYTE: issue a read for byte (word_idx<<2)+k, k=0..3. The array is synchronous with 1-cycle latency;
//    each byte is captured into rdata[8k+7:8k] the following cycle. RD_WAIT captures lane 3, then go to RD_RESP.
//  - CPU priority: a cycle with cpu_ce_n=0 belongs to the CPU. The AXI FSM stalls in place; k does not advance.
//    A capture already in flight still completes.
//  - Byte order is little-endian: lane 0 is the lowest byte address.
//  - Uncontended latency: write, accept cycle to bvalid = 5 cycles. Read, accept cycle to rvalid = 6 cycles.
//  - WR_RESP/RD_RESP: hold bvalid/rvalid and their data/resp stable until the ready input is seen high;
//    then go to IDLE the next cycle. Back-to-back transactions are separated by at least 1 IDLE cycle.
//  - Address handling: addr[10:2] is the word index. Addresses >= RAM_DEPTH alias, unless the option below is on.
//  - Async reset mid-transaction aborts it. No response is issued and partial byte writes stay in the array.
// CONFIGURATION
//  ATARI_6116_ADDR_CHECK_EN
//   defined:   any awaddr/araddr with a bit set above bit 10 skips the byte phase entirely.
//              Response is SLVERR (2'b10) on the next cycle, and rdata=0.
//   undefined: addresses alias modulo RAM_DEPTH and the response is always OKAY.
// STRUCTURE
//  - Package atari_6116_pkg: RESP_OKAY/RESP_SLVERR constants, the FSM state typedef, RAM_ADDR_W=11, BYTE_LANES=4.
//  - Sub-module atari_6116_ram: 2048x8 single-port synchronous RAM with ports clk, we, addr[10:0], din, dout.
//    Read latency is 1 cycle.
//  - Top level holds the FSM, the lane counter, the CPU/AXI address, data and WE mux, and the response registers.
// TESTING
//  1. Write then read back 0x0101FFFF@0x0, 0xabcd0001@0x4, 0xdead0011@0x8, 0xbeef0011@0xC, strb=F
//     -> each read returns identical data; bresp=rresp=OKAY; bvalid appears 5 cycles after accept.
//  2. Write 0x11223344@0x10 strb=F, then 0xAABBCCDD@0x10 strb=4'b0101 -> read 0x11BB33DD.
//  3. cpu_ce_n=0 held for 3 cycles during a write's byte phase -> bvalid is delayed by exactly 3 cycles;
//     CPU write of 0x5A@0x7FF with cpu_we_n=0 -> AXI read @0x7FC gives [31:24]=0x5A.
//  4. AXI write 0xCAFEF00D@0x20, then CPU read cpu_addr=0x021 -> cpu_dout=0xF0 one cycle later.
//  5. awvalid, wvalid and arvalid all raised in the same cycle -> write accepted first, read accepted after bready.
//     rready held low 4 cycles -> rvalid/rdata held stable throughout.
//  6. Address 0x800 with ATARI_6116_ADDR_CHECK_EN defined -> SLVERR and rdata=0.
//     Without the macro -> write aliases to 0x000. Reset asserted mid-read -> all valids drop to 0 immediately.

Source files
------------

// File: rtl/atari_6116_pkg.sv
// Shared definitions for the AXI4-Lite front end of the emulated 6116 2Kx8 static RAM.
//   RESP_OKAY / RESP_SLVERR : AXI response codes driven on bresp/rresp
//   RAM_ADDR_W              : byte address width of the 2K array
//   BYTE_LANES / LANE_W     : bytes per 32-bit AXI word and width of the lane counter
//   state_e                 : AXI-side sequencer states
package atari_6116_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned RAM_ADDR_W = 11;
  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned LANE_W     = $clog2(BYTE_LANES);

  typedef enum logic [2:0] {
    StIdle,
    StWrByte,
    StWrResp,
    StRdByte,
    StRdWait,
    StRdResp
  } state_e;

endpackage

// File: rtl/atari_6116_ram.sv
// Single-port synchronous byte array standing in for the 6116 cell matrix.
//   clk  : rising-edge clock
//   we   : write enable for the addressed byte
//   addr : byte address
//   din  : write data
//   dout : read data, registered; reflects the byte addressed on the previous edge
// Read-before-write on a collision. Contents are deliberately not reset.
module atari_6116_ram
  import atari_6116_pkg::*;
#(
  parameter int unsigned DEPTH = 2048
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [RAM_ADDR_W-1:0] addr,
  input  logic [7:0]            din,
  output logic [7:0]            dout
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/atari_6116_axil_port.sv
// AXI4-Lite slave port onto the emulated 6116 2Kx8 SRAM, shared with the CPU's native pin port.
// Each 32-bit AXI access is serialised into four byte cycles (little-endian, lane 0 = lowest
// byte). Any cycle with cpu_ce_n low belongs to the CPU; the AXI byte sequencer waits in place.
//   s00_axi_aclk / s00_axi_areset : clock and asynchronous active-high reset
//   s00_axi_aw* / w* / b*         : write address, write data and write response channels
//   s00_axi_ar* / r*              : read address and read data channels
//   cpu_ce_n, cpu_we_n            : CPU chip/write enables, active low
//   cpu_addr, cpu_din, cpu_dout   : CPU byte address, write data and read data
// Optional build macro ATARI_6116_ADDR_CHECK_EN: addresses with any bit set above bit 10 get
// SLVERR without touching the array (rdata=0). Without it such addresses alias into the 2K.
module atari_6116_axil_port
  import atari_6116_pkg::*;
#(
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 32,
  parameter int unsigned RAM_DEPTH            = 2048
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic                              cpu_ce_n,
  input  logic                              cpu_we_n,
  input  logic [RAM_ADDR_W-1:0]             cpu_addr,
  input  logic [7:0]                        cpu_din,
  output logic [7:0]                        cpu_dout
);

  localparam int unsigned WORD_W = RAM_ADDR_W - LANE_W;
  localparam int unsigned STRB_W = C_S00_AXI_DATA_WIDTH / 8;
  localparam logic [LANE_W-1:0] LastLane = LANE_W'(BYTE_LANES - 1);

  state_e                            state_q;
  logic [LANE_W-1:0]                 lane_q;
  logic [WORD_W-1:0]                 word_q;
  logic                              addr_bad_q;
  logic [C_S00_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]                 wstrb_q;

  logic                              awready_q;
  logic                              wready_q;
  logic                              arready_q;
  logic                              bvalid_q;
  logic                              rvalid_q;
  logic [1:0]                        bresp_q;
  logic [1:0]                        rresp_q;
  logic [C_S00_AXI_DATA_WIDTH-1:0]   rdata_q;

  // A read issued on one edge returns its byte on the next; these remember where it goes.
  logic                              cap_pend_q;
  logic [LANE_W-1:0]                 cap_lane_q;

  logic                              cpu_rd_q;
  logic [7:0]                        cpu_dout_q;

  logic                              cpu_active;
  logic                              aw_bad;
  logic                              ar_bad;

  logic                              ram_we;
  logic [RAM_ADDR_W-1:0]             ram_addr;
  logic [7:0]                        ram_din;
  logic [7:0]                        ram_dout;

  assign cpu_active = ~cpu_ce_n;

`ifdef ATARI_6116_ADDR_CHECK_EN
  assign aw_bad = |s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:RAM_ADDR_W];
  assign ar_bad = |s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:RAM_ADDR_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s00_axi_awaddr[LANE_W-1:0], s00_axi_araddr[LANE_W-1:0]};
`else
  assign aw_bad = 1'b0;
  assign ar_bad = 1'b0;

  // Upper address bits are ignored so that the array aliases across the address space.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:RAM_ADDR_W],
                              s00_axi_awaddr[LANE_W-1:0],
                              s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:RAM_ADDR_W],
                              s00_axi_araddr[LANE_W-1:0]};
`endif

  // Array port mux: the CPU owns every cycle it enables the chip.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    if (cpu_active) begin
      ram_we = ~cpu_we_n;
    end else begin
      ram_addr = {word_q, lane_q};
      ram_din  = wdata_q[{lane_q, 3'b000} +: 8];
      ram_we   = (state_q == StWrByte) && wstrb_q[lane_q];
    end
  end

  atari_6116_ram #(
    .DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk  (s00_axi_aclk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      state_q    <= StIdle;
      lane_q     <= '0;
      word_q     <= '0;
      addr_bad_q <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      cap_pend_q <= 1'b0;
      cap_lane_q <= '0;
      cpu_rd_q   <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      cap_pend_q <= 1'b0;
      cpu_rd_q   <= cpu_active & cpu_we_n;

      if (cpu_rd_q) begin
        cpu_dout_q <= ram_dout;
      end

      // Completes even on a CPU-owned cycle: the byte was read on the previous edge.
      if (cap_pend_q) begin
        rdata_q[{cap_lane_q, 3'b000} +: 8] <= ram_dout;
      end

      unique case (state_q)
        StIdle: begin
          if (awready_q) begin
            // Ready pulse just completed the AW/W handshake.
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            lane_q    <= '0;
            if (addr_bad_q) begin
              state_q  <= StWrResp;
              bvalid_q <= 1'b1;
              bresp_q  <= RESP_SLVERR;
            end else begin
              state_q <= StWrByte;
            end
          end else if (arready_q) begin
            arready_q <= 1'b0;
            lane_q    <= '0;
            if (addr_bad_q) begin
              state_q  <= StRdResp;
              rvalid_q <= 1'b1;
              rresp_q  <= RESP_SLVERR;
              rdata_q  <= '0;
            end else begin
              state_q <= StRdByte;
            end
          end else if (s00_axi_awvalid && s00_axi_wvalid) begin
            // Only a complete address+data pair is taken; it also wins over a read.
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            word_q     <= s00_axi_awaddr[RAM_ADDR_W-1:LANE_W];
            wdata_q    <= s00_axi_wdata;
            wstrb_q    <= s00_axi_wstrb;
            addr_bad_q <= aw_bad;
          end else if (s00_axi_arvalid) begin
            arready_q  <= 1'b1;
            word_q     <= s00_axi_araddr[RAM_ADDR_W-1:LANE_W];
            addr_bad_q <= ar_bad;
          end
        end

        StWrByte: begin
          if (!cpu_active) begin
            lane_q <= lane_q + 1'b1;
            if (lane_q == LastLane) begin
              state_q  <= StWrResp;
              bvalid_q <= 1'b1;
              bresp_q  <= RESP_OKAY;
            end
          end
        end

        StWrResp: begin
          if (s00_axi_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end

        StRdByte: begin
          if (!cpu_active) begin
            cap_pend_q <= 1'b1;
            cap_lane_q <= lane_q;
            lane_q     <= lane_q + 1'b1;
            if (lane_q == LastLane) begin
              state_q <= StRdWait;
            end
          end
        end

        StRdWait: begin
          // Lane 3 lands in rdata on this same edge.
          state_q  <= StRdResp;
          rvalid_q <= 1'b1;
          rresp_q  <= RESP_OKAY;
        end

        StRdResp: begin
          if (s00_axi_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;

  // Fresh byte on the cycle after a CPU read, the last CPU byte otherwise.
  assign cpu_dout = cpu_rd_q ? ram_dout : cpu_dout_q;

endmodule
